// File: rtl/apu_issue_queue_if.sv
// apu_issue_queue_if: core-side and decoder-side handshake bundle for apu_issue_queue
interface apu_issue_queue_if #(parameter int DEPTH = 4);
  localparam int OW = $clog2(DEPTH + 1);
  logic             apu_req_i;
  logic             apu_gnt_o;
  logic [2:0][31:0] apu_operands_i;
  logic [5:0]       apu_op_i;
  logic [14:0]      apu_flags_i;
  logic             apu_rvalid_o;
  logic             dec_req_o;
  logic             dec_gnt_i;
  logic [2:0][31:0] dec_operands_o;
  logic [5:0]       dec_op_o;
  logic [14:0]      dec_flags_o;
  logic             dec_rvalid_i;
  logic             flush_i;
  logic [OW-1:0]    occupancy_o;
  logic             busy_o;
  logic             protocol_err_o;
  modport slave (
    input  apu_req_i, apu_operands_i, apu_op_i, apu_flags_i, dec_gnt_i, dec_rvalid_i, flush_i,
    output apu_gnt_o, apu_rvalid_o, dec_req_o, dec_operands_o, dec_op_o, dec_flags_o,
           occupancy_o, busy_o, protocol_err_o
  );
  modport master (
    output apu_req_i, apu_operands_i, apu_op_i, apu_flags_i, dec_gnt_i, dec_rvalid_i, flush_i,
    input  apu_gnt_o, apu_rvalid_o, dec_req_o, dec_operands_o, dec_op_o, dec_flags_o,
           occupancy_o, busy_o, protocol_err_o
  );
endinterface

// File: rtl/apu_issue_queue.sv
// apu_issue_queue: circular FIFO between core and vector decoder; ISSUE_QUEUE_BYPASS_EN enables empty-queue bypass
module apu_issue_queue #(
  parameter int DEPTH = 4
) (
  input logic             clk,
  input logic             reset,
  apu_issue_queue_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  typedef struct packed {
    logic [2:0][31:0] ops;
    logic [5:0]       op;
    logic [14:0]      flags;
  } entry_t;
  entry_t        r_mem [DEPTH];
  logic [AW-1:0] r_wp, r_rp;
  logic [CW-1:0] r_cnt;
  logic          r_in_flight, r_err;
  logic          w_full, w_empty, w_byp, w_issue, w_push, w_pop;
  entry_t        w_in;
  assign w_in    = {bus.apu_operands_i, bus.apu_op_i, bus.apu_flags_i};
  assign w_full  = r_cnt == CW'(DEPTH);
  assign w_empty = r_cnt == '0;
`ifdef ISSUE_QUEUE_BYPASS_EN
  assign w_byp = w_empty & ~bus.flush_i;
  assign {bus.dec_operands_o, bus.dec_op_o, bus.dec_flags_o} = w_byp ? w_in : r_mem[r_rp];
`else
  assign w_byp = 1'b0;
  assign {bus.dec_operands_o, bus.dec_op_o, bus.dec_flags_o} = r_mem[r_rp];
`endif
  assign bus.apu_gnt_o      = ~w_full & ~bus.flush_i & ~reset;
  assign bus.dec_req_o      = ~reset & ~bus.flush_i & (w_byp ? bus.apu_req_i : ~w_empty);
  assign bus.apu_rvalid_o   = bus.dec_rvalid_i;
  assign bus.occupancy_o    = reset ? '0 : r_cnt;
  assign bus.busy_o         = ~reset & ((r_cnt != '0) | r_in_flight);
  assign bus.protocol_err_o = ~reset & r_err;
  assign w_issue = bus.dec_req_o & bus.dec_gnt_i;
  assign w_pop   = w_issue & ~w_byp;
  // a bypassed grant consumes the offer directly, so nothing is stored
  assign w_push  = bus.apu_req_i & bus.apu_gnt_o & ~(w_byp & w_issue);
  always_ff @(posedge clk)
    if (w_push) r_mem[r_wp] <= w_in;
  always_ff @(posedge clk) begin
    if (reset) begin
      r_wp        <= '0;
      r_rp        <= '0;
      r_cnt       <= '0;
      r_in_flight <= 1'b0;
      r_err       <= 1'b0;
    end else begin
      r_in_flight <= w_issue | (r_in_flight & ~bus.dec_rvalid_i);
      r_err       <= r_err | (bus.dec_rvalid_i & ~r_in_flight);
      if (bus.flush_i) begin
        r_rp  <= r_wp;
        r_cnt <= '0;
      end else begin
        if (w_push) r_wp <= r_wp + AW'(1);
        if (w_pop) r_rp <= r_rp + AW'(1);
        r_cnt <= r_cnt + CW'(w_push) - CW'(w_pop);
      end
    end
  end
endmodule

// File: tb/tb_apu_issue_queue.sv
// tb_apu_issue_queue: directed scenarios plus random traffic checked against a queue-based model
module tb_apu_issue_queue;
  localparam int DEPTH = 4;
  typedef struct packed {
    logic [95:0] ops;
    logic [5:0]  op;
    logic [14:0] flags;
  } ent_t;
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;
  apu_issue_queue_if #(.DEPTH(DEPTH)) bus();
  apu_issue_queue #(.DEPTH(DEPTH)) dut (.clk(clk), .reset(reset), .bus(bus));
  ent_t q[$];
  ent_t last_in;
  ent_t saved[3];
  bit   m_infl = 1'b0;
  bit   m_err = 1'b0;
  int   n_chk = 0;
  int   n_fail = 0;
  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic cyc(input bit rq, input bit gt, input bit rv, input bit fl, input bit rs);
    ent_t in_e, head;
    bit empty, byp, e_gnt, e_req, issue;
    int n;
    @(negedge clk);
    reset = rs;
    bus.apu_req_i = rq;
    bus.dec_gnt_i = gt;
    bus.dec_rvalid_i = rv;
    bus.flush_i = fl;
    bus.apu_operands_i = {$urandom(), $urandom(), $urandom()};
    bus.apu_op_i = 6'($urandom());
    bus.apu_flags_i = 15'($urandom());
    in_e = {bus.apu_operands_i, bus.apu_op_i, bus.apu_flags_i};
    last_in = in_e;
    #1;
    n = q.size();
    empty = n == 0;
    byp = 1'b0;
`ifdef ISSUE_QUEUE_BYPASS_EN
    byp = empty && !fl;
`endif
    e_gnt = n < DEPTH && !fl && !rs;
    e_req = !rs && !fl && (empty ? (byp && rq) : 1'b1);
    issue = e_req && gt;
    head = empty ? in_e : q[0];
    chk("apu_gnt", bus.apu_gnt_o, e_gnt);
    chk("dec_req", bus.dec_req_o, e_req);
    chk("apu_rvalid", bus.apu_rvalid_o, rv);
    chk("occupancy", bus.occupancy_o, rs ? 0 : n);
    chk("busy", bus.busy_o, !rs && (n != 0 || m_infl));
    chk("protocol_err", bus.protocol_err_o, !rs && m_err);
    if (e_req) begin
      chk("dec_operands", bus.dec_operands_o, head.ops);
      chk("dec_op", bus.dec_op_o, head.op);
      chk("dec_flags", bus.dec_flags_o, head.flags);
    end
    @(posedge clk);
    if (rs) begin
      q.delete();
      m_infl = 1'b0;
      m_err = 1'b0;
    end else begin
      if (rv && !m_infl) m_err = 1'b1;
      m_infl = issue ? 1'b1 : (rv ? 1'b0 : m_infl);
      if (fl) q.delete();
      else begin
        if (issue && !byp) void'(q.pop_front());
        if (rq && e_gnt && !(byp && issue)) q.push_back(in_e);
      end
    end
  endtask
  initial begin
    bus.apu_req_i = 1'b0;
    bus.dec_gnt_i = 1'b0;
    bus.dec_rvalid_i = 1'b0;
    bus.flush_i = 1'b0;
    bus.apu_operands_i = '0;
    bus.apu_op_i = '0;
    bus.apu_flags_i = '0;
    cyc(0, 0, 0, 0, 1);
    cyc(0, 0, 0, 0, 1);
    cyc(0, 0, 0, 0, 0);
    #1 chk("gnt_after_reset", bus.apu_gnt_o, 1);
    for (int i = 0; i < 4; i++) cyc(1, 0, 0, 0, 0);
    #1 chk("occ_full", bus.occupancy_o, 4);
    chk("gnt_full", bus.apu_gnt_o, 0);
    cyc(1, 0, 0, 0, 0);
    #1 chk("occ_fifth_held", bus.occupancy_o, 4);
    cyc(1, 1, 0, 0, 0);
    #1 chk("occ_after_issue", bus.occupancy_o, 3);
    chk("gnt_after_issue", bus.apu_gnt_o, 1);
    cyc(0, 0, 1, 0, 0);
    cyc(0, 0, 0, 1, 0);
    #1 chk("occ_flushed", bus.occupancy_o, 0);
    for (int i = 0; i < 3; i++) begin
      cyc(1, 0, 0, 0, 0);
      saved[i] = last_in;
    end
    for (int i = 0; i < 3; i++) begin
      #1 chk("order_head", bus.dec_operands_o, saved[i].ops);
      cyc(0, 1, 0, 0, 0);
      cyc(0, 0, 1, 0, 0);
    end
    #1 chk("busy_after_c", bus.busy_o, 0);
    for (int i = 0; i < 4; i++) cyc(1, 0, 0, 0, 0);
    cyc(0, 1, 0, 0, 0);
    #1 chk("occ3_in_flight", bus.occupancy_o, 3);
    cyc(1, 0, 0, 1, 0);
    #1 chk("occ_after_flush", bus.occupancy_o, 0);
    chk("busy_in_flight", bus.busy_o, 1);
    cyc(0, 0, 1, 0, 0);
    #1 chk("err_clean_completion", bus.protocol_err_o, 0);
    chk("busy_drained", bus.busy_o, 0);
    cyc(0, 0, 1, 0, 0);
    #1 chk("err_set", bus.protocol_err_o, 1);
    for (int i = 0; i < 3; i++) cyc(0, 0, 0, 0, 0);
    #1 chk("err_sticky", bus.protocol_err_o, 1);
    cyc(0, 0, 0, 0, 1);
    cyc(0, 0, 0, 0, 0);
    #1 chk("err_cleared", bus.protocol_err_o, 0);
    cyc(1, 1, 0, 0, 0);
`ifdef ISSUE_QUEUE_BYPASS_EN
    #1 chk("bypass_occ", bus.occupancy_o, 0);
    chk("bypass_busy", bus.busy_o, 1);
`else
    #1 chk("nobypass_occ", bus.occupancy_o, 1);
    chk("nobypass_dec_req", bus.dec_req_o, 1);
    cyc(0, 1, 0, 0, 0);
`endif
    cyc(0, 0, 1, 0, 0);
    for (int i = 0; i < 3000; i++) begin
      cyc($urandom_range(0, 9) < 6, $urandom_range(0, 1) == 1,
          m_infl ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 49) == 0),
          $urandom_range(0, 19) == 0, $urandom_range(0, 99) == 0);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
